dbus_sram_bridge: RTL and testbench
===================================

// Module: dbus_sram_bridge
// PURPOSE
// - Responder for the data-bus port driven by the data MMU: dbus_en/dbus_wen/dbus_paddr/dbus_wdata in,
//   dbus_rdata/dbus_streq out.
// - Converts each access into one SRAM-like transaction (req/addr_ok/data_ok) toward the memory/AXI side.
// - Holds the pipeline via dbus_streq while a transaction is in flight.
// - Sits between the MMU and the external data SRAM-like master port.
// PARAMETERS
// - TIMEOUT_CYC  0   cycles allowed in REQ+WAIT before abort; 0 = timeout disabled
// PORTS
// - clk            in   1   clock; all state updates on rising edge
// - rst            in   1   reset, synchronous, active-high
// - dbus_en        in   1   access request; already gated by the exception flag upstream
// - dbus_wen       in   4   byte write enables; 4'b0000 = read
// - dbus_paddr     in   32  physical address
// - dbus_wdata     in   32  write data, byte lanes already positioned
// - dbus_rdata     out  32  read data, registered
// - dbus_streq     out  1   stall request to pipeline control
// - pl_stall       in   1   MEM stage is held this cycle for another reason
// - data_req       out  1   SRAM-like request, registered
// - data_wr        out  1   1 = write
// - data_size      out  2   0 = byte, 1 = half, 2 = word
// - data_addr      out  32  transaction address
// - data_wdata     out  32  write data
// - data_addr_ok   in   1   request accepted
// - data_data_ok   in   1   transaction complete; rdata valid for reads
// - data_rdata     in   32  read data
// - bus_err        out  1   one-cycle pulse on timeout abort
// BEHAVIOUR
// - FSM states: IDLE, REQ, WAIT, DONE. Reset: state = IDLE; every output register = 0.
// - IDLE:
//   - dbus_en=1: latch request into data_* registers, go to REQ.
//   - data_wr = |dbus_wen.
// - Size/address mapping:
//   - wen 1111 or read: size 2, addr[1:0] = 0.
//   - 0011/1100: size 1, addr[1:0] = {wen[2], 0}.
//   - One-hot: size 0, addr[1:0] = lane index.
//   - Any other nonzero pattern: size 2, addr[1:0] = 0.
// - REQ:
//   - data_req = 1; all data_* outputs held stable until data_addr_ok.
//   - addr_ok & !data_ok: go to WAIT.
//   - addr_ok & data_ok in the same cycle: go to DONE.
//   - data_req drops the cycle after addr_ok.
// - WAIT: data_req = 0; on data_ok go to DONE.
// - Read capture: dbus_rdata <= data_rdata on the accepting data_ok of a read. Otherwise dbus_rdata holds.
// - DONE:
//   - dbus_streq = 0; pipeline advances this cycle.
//   - pl_stall=1: stay in DONE (same request still presented; must not reissue).
//   - pl_stall=0: go to IDLE.
// - dbus_streq is combinational:
//   - (state==IDLE & dbus_en) | state==REQ | state==WAIT.
//   - Never 1 in DONE.
// - Minimum latency with zero-wait slave (addr_ok in REQ, data_ok next cycle): 3 stall cycles, DONE on 4th.
// - Timeout (TIMEOUT_CYC>0):
//   - Counter clears on entry to REQ and counts REQ+WAIT cycles.
//   - When count == TIMEOUT_CYC-1 without completion: bus_err = 1 next cycle, dbus_rdata = 0, go to DONE, data_req = 0.
//   - The counter saturates and never wraps.
// - data_ok or addr_ok received in IDLE/DONE is ignored. No state or rdata change.
// - rst during REQ/WAIT/DONE: state returns to IDLE next edge, data_req = 0 immediately after the edge, and the in-flight transaction is dropped.
// - dbus_paddr/wen changes while in REQ/WAIT are ignored; latched values are used.
// - One outstanding transaction maximum.
// TESTING
// - Word read:
//   - Stimulus: en=1, wen=0, paddr=0x1FC0_0104; slave addr_ok in cycle 1, data_ok with rdata=0xDEADBEEF in cycle 2.
//   - Required: streq high cycles 0-2, DONE cycle 3, dbus_rdata=0xDEADBEEF, size=2, addr=0x1FC0_0104.
// - Byte write:
//   - Stimulus: wen=4'b0100, paddr=0x0000_1002, wdata=0x00AB0000.
//   - Required: data_wr=1, size=0, addr=0x0000_1002, wdata=0x00AB0000; dbus_rdata unchanged.
// - Delayed accept:
//   - Stimulus: addr_ok held low 3 cycles.
//   - Required: data_req/addr/size/wdata stable all 3 cycles; a single transaction occurs.
// - Pipeline hold:
//   - Stimulus: pl_stall=1 for 2 cycles in DONE with en still high.
//   - Required: no new data_req; streq=0; IDLE reached after pl_stall falls.
// - Reset mid-op:
//   - Stimulus: rst pulsed in WAIT; stray data_ok arrives the following cycle.
//   - Required: IDLE, data_req=0, rdata=0, stray data_ok ignored.
// - Timeout:
//   - Stimulus: TIMEOUT_CYC=8, slave never answers.
//   - Required: bus_err pulses once 8 cycles after REQ entry, dbus_rdata=0, streq drops.

Source files
------------

// File: rtl/dbus_sram_bridge.sv
// Data-bus responder: turns each MMU data access into one SRAM-like transaction
// and stalls the pipeline until it completes, is aborted by timeout, or is reset.
module dbus_sram_bridge #(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbus_en,
  input  logic [3:0]  dbus_wen,
  input  logic [31:0] dbus_paddr,
  input  logic [31:0] dbus_wdata,
  output logic [31:0] dbus_rdata,
  output logic        dbus_streq,
  input  logic        pl_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  logic        complete;
  logic        tmo_abort;
  logic        accept;
  logic [1:0]  size_map;
  logic [1:0]  off_map;

  // Byte-enable pattern to transfer size and low address bits.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    size_map = 2'd2;
    off_map  = 2'd0;
    case (dbus_wen)
      4'b0011: begin size_map = 2'd1; off_map = 2'd0; end
      4'b1100: begin size_map = 2'd1; off_map = 2'd2; end
      4'b0001: begin size_map = 2'd0; off_map = 2'd0; end
      4'b0010: begin size_map = 2'd0; off_map = 2'd1; end
      4'b0100: begin size_map = 2'd0; off_map = 2'd2; end
      4'b1000: begin size_map = 2'd0; off_map = 2'd3; end
      default: begin size_map = 2'd2; off_map = 2'd0; end
    endcase
  end

  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TIMEOUT_CYC - 1);
  assign accept  = (state == IDLE) && dbus_en;

  always_comb begin
    state_nxt  = state;
    dbus_streq = 1'b0;
    complete   = 1'b0;
    tmo_abort  = 1'b0;
    case (state)
      IDLE: begin
        dbus_streq = dbus_en;
        if (dbus_en) state_nxt = REQ;
      end
      REQ: begin
        dbus_streq = 1'b1;
        if (data_addr_ok && data_data_ok) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = DONE;
        end else if (data_addr_ok) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        dbus_streq = 1'b1;
        if (data_data_ok) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // The pipeline keeps presenting the same access while held; it is never reissued.
        if (!pl_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= '0;
      dbus_rdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bus_err <= tmo_abort;

      if (accept) begin
        data_req   <= 1'b1;
        data_wr    <= |dbus_wen;
        data_size  <= size_map;
        data_addr  <= {dbus_paddr[31:2], off_map};
        data_wdata <= dbus_wdata;
      end else if ((state == REQ) && (data_addr_ok || tmo_abort)) begin
        data_req <= 1'b0;
      end

      // Saturating so a long stall with a large limit can never wrap into a false match.
      if (accept) begin
        tmo_cnt <= '0;
      end else if (((state == REQ) || (state == WAIT)) && (tmo_cnt != '1)) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end

      if (tmo_abort) begin
        dbus_rdata <= '0;
      end else if (complete && !data_wr) begin
        dbus_rdata <= data_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_bridge.sv
// Directed bench for dbus_sram_bridge: each task drives one scenario and checks inline.
module tb_dbus_sram_bridge;

  logic        clk;
  logic        rst;
  logic        dbus_en;
  logic [3:0]  dbus_wen;
  logic [31:0] dbus_paddr;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_streq;
  logic        pl_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_err;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  dbus_sram_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .dbus_en      (dbus_en),
    .dbus_wen     (dbus_wen),
    .dbus_paddr   (dbus_paddr),
    .dbus_wdata   (dbus_wdata),
    .dbus_rdata   (dbus_rdata),
    .dbus_streq   (dbus_streq),
    .pl_stall     (pl_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted address handshakes seen on the bus.
  always @(posedge clk) begin
    if (data_req === 1'b1 && data_addr_ok === 1'b1) hs_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dbus_en = 1'b0; dbus_wen = 4'b0; dbus_paddr = '0; dbus_wdata = '0;
    pl_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    cyc(); cyc(); settle();
    total++;
    if ({data_req, data_wr, data_size, data_addr, data_wdata, dbus_rdata, bus_err, dbus_streq} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b wr=%b size=%0d addr=%h wdata=%h rdata=%h err=%b streq=%b want all 0",
               data_req, data_wr, data_size, data_addr, data_wdata, dbus_rdata, bus_err, dbus_streq);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_word_read();
    int hs0;
    hs0 = hs_cnt;
    dbus_en = 1'b1; dbus_wen = 4'b0000; dbus_paddr = 32'h1FC0_0104;
    settle();
    total++; if (dbus_streq !== 1'b1) begin bad++; $display("FAIL rd_streq_c0: got=%b want=1", dbus_streq); end
    cyc();
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL rd_req_c1: got=%b want=1", data_req); end
    total++; if (data_size !== 2'd2 || data_addr !== 32'h1FC0_0104 || data_wr !== 1'b0) begin
      bad++; $display("FAIL rd_fields: size=%0d addr=%h wr=%b want 2 1fc00104 0", data_size, data_addr, data_wr);
    end
    total++; if (dbus_streq !== 1'b1) begin bad++; $display("FAIL rd_streq_c1: got=%b want=1", dbus_streq); end
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    settle();
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL rd_req_c2: got=%b want=0", data_req); end
    total++; if (dbus_streq !== 1'b1) begin bad++; $display("FAIL rd_streq_c2: got=%b want=1", dbus_streq); end
    cyc();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    settle();
    total++; if (dbus_streq !== 1'b0) begin bad++; $display("FAIL rd_streq_done: got=%b want=0", dbus_streq); end
    total++; if (dbus_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rdata: got=%h want=deadbeef", dbus_rdata); end
    dbus_en = 1'b0;
    cyc();
    total++; if (dbus_streq !== 1'b0 || data_req !== 1'b0) begin
      bad++; $display("FAIL rd_idle: streq=%b req=%b want 0 0", dbus_streq, data_req);
    end
    total++; if (hs_cnt !== hs0 + 1) begin bad++; $display("FAIL rd_single_hs: got=%0d want=%0d", hs_cnt - hs0, 1); end
  endtask

  task automatic test_byte_write();
    dbus_en = 1'b1; dbus_wen = 4'b0100; dbus_paddr = 32'h0000_1002; dbus_wdata = 32'h00AB_0000;
    cyc();
    total++; if (data_wr !== 1'b1 || data_size !== 2'd0 || data_addr !== 32'h0000_1002 || data_wdata !== 32'h00AB_0000) begin
      bad++; $display("FAIL wr_fields: wr=%b size=%0d addr=%h wdata=%h want 1 0 00001002 00ab0000",
                      data_wr, data_size, data_addr, data_wdata);
    end
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    settle();
    total++; if (dbus_streq !== 1'b0) begin bad++; $display("FAIL wr_streq_done: got=%b want=0", dbus_streq); end
    total++; if (dbus_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_rdata_hold: got=%h want=deadbeef", dbus_rdata); end
    dbus_en = 1'b0; dbus_wen = 4'b0;
    cyc();
  endtask

  task automatic test_size_map();
    logic [3:0] wen_tab  [10] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001,
                                  4'b0010, 4'b0100, 4'b1000, 4'b0101, 4'b0111};
    logic [1:0] size_tab [10] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    logic [1:0] off_tab  [10] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    logic [31:0] exp_addr;
    for (int i = 0; i < 10; i++) begin
      dbus_en = 1'b1; dbus_wen = wen_tab[i]; dbus_paddr = 32'h8000_00F3; dbus_wdata = 32'h0;
      exp_addr = {30'h2000_003C, off_tab[i]};
      cyc();
      total++;
      if (data_size !== size_tab[i] || data_addr !== exp_addr || data_wr !== (wen_tab[i] != 4'b0)) begin
        bad++; $display("FAIL size_map[%0d]: wen=%b size=%0d addr=%h wr=%b want %0d %h %b", i, wen_tab[i],
                        data_size, data_addr, data_wr, size_tab[i], exp_addr, wen_tab[i] != 4'b0);
      end
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
      cyc();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; dbus_en = 1'b0;
      cyc();
    end
  endtask

  task automatic test_delayed_accept();
    int hs0;
    hs0 = hs_cnt;
    dbus_en = 1'b1; dbus_wen = 4'b1100; dbus_paddr = 32'h2000_0001; dbus_wdata = 32'hA5A5_0000;
    cyc();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (data_req !== 1'b1 || data_addr !== 32'h2000_0002 || data_size !== 2'd1 ||
          data_wdata !== 32'hA5A5_0000 || data_wr !== 1'b1 || dbus_streq !== 1'b1) begin
        bad++; $display("FAIL delay_stable[%0d]: req=%b addr=%h size=%0d wdata=%h wr=%b streq=%b want 1 20000002 1 a5a50000 1 1",
                        i, data_req, data_addr, data_size, data_wdata, data_wr, dbus_streq);
      end
      dbus_paddr = 32'hFFFF_FFFF; dbus_wen = 4'b0001; dbus_wdata = 32'h1111_1111;
      cyc();
    end
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0;
    settle();
    total++; if (data_req !== 1'b0 || dbus_streq !== 1'b1 || data_addr !== 32'h2000_0002) begin
      bad++; $display("FAIL delay_wait: req=%b streq=%b addr=%h want 0 1 20000002", data_req, dbus_streq, data_addr);
    end
    data_data_ok = 1'b1;
    cyc();
    data_data_ok = 1'b0; dbus_en = 1'b0;
    settle();
    total++; if (dbus_streq !== 1'b0) begin bad++; $display("FAIL delay_done_streq: got=%b want=0", dbus_streq); end
    cyc();
    total++; if (hs_cnt !== hs0 + 1) begin bad++; $display("FAIL delay_single_hs: got=%0d want=1", hs_cnt - hs0); end
  endtask

  task automatic test_pipeline_hold();
    int hs0;
    hs0 = hs_cnt;
    dbus_en = 1'b1; dbus_wen = 4'b0000; dbus_paddr = 32'h0000_0100;
    cyc();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
    cyc();
    data_rdata = 32'h9999_9999; pl_stall = 1'b1;
    settle();
    total++; if (dbus_streq !== 1'b0 || dbus_rdata !== 32'h1111_2222) begin
      bad++; $display("FAIL hold_done0: streq=%b rdata=%h want 0 11112222", dbus_streq, dbus_rdata);
    end
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    settle();
    total++; if (dbus_streq !== 1'b0 || data_req !== 1'b0 || dbus_rdata !== 32'h1111_2222) begin
      bad++; $display("FAIL hold_done1: streq=%b req=%b rdata=%h want 0 0 11112222", dbus_streq, data_req, dbus_rdata);
    end
    pl_stall = 1'b0;
    cyc();
    total++; if (dbus_streq !== 1'b1 || data_req !== 1'b0) begin
      bad++; $display("FAIL hold_idle: streq=%b req=%b want 1 0", dbus_streq, data_req);
    end
    dbus_en = 1'b0;
    settle();
    total++; if (dbus_streq !== 1'b0) begin bad++; $display("FAIL hold_idle_noen: got=%b want=0", dbus_streq); end
    cyc();
    total++; if (data_req !== 1'b0 || hs_cnt !== hs0 + 1) begin
      bad++; $display("FAIL hold_no_reissue: req=%b hs=%0d want 0 1", data_req, hs_cnt - hs0);
    end
  endtask

  task automatic test_reset_midop();
    dbus_en = 1'b1; dbus_wen = 4'b0000; dbus_paddr = 32'h0000_0200;
    cyc();
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0; rst = 1'b1;
    settle();
    total++; if (dbus_streq !== 1'b1) begin bad++; $display("FAIL rstm_wait_streq: got=%b want=1", dbus_streq); end
    cyc();
    rst = 1'b0; dbus_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    settle();
    total++; if (data_req !== 1'b0 || dbus_rdata !== 32'h0 || dbus_streq !== 1'b0) begin
      bad++; $display("FAIL rstm_after: req=%b rdata=%h streq=%b want 0 0 0", data_req, dbus_rdata, dbus_streq);
    end
    cyc();
    data_data_ok = 1'b0;
    settle();
    total++; if (data_req !== 1'b0 || dbus_rdata !== 32'h0 || dbus_streq !== 1'b0) begin
      bad++; $display("FAIL rstm_stray: req=%b rdata=%h streq=%b want 0 0 0", data_req, dbus_rdata, dbus_streq);
    end
    cyc();
  endtask

  task automatic test_timeout();
    int hs0;
    int err_cnt;
    dbus_en = 1'b1; dbus_wen = 4'b0000; dbus_paddr = 32'h0000_0300;
    cyc();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h5A5A_5A5A;
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; dbus_en = 1'b0;
    cyc();
    total++; if (dbus_rdata !== 32'h5A5A_5A5A) begin bad++; $display("FAIL tmo_preload: got=%h want=5a5a5a5a", dbus_rdata); end
    hs0 = hs_cnt;
    err_cnt = 0;
    dbus_en = 1'b1; dbus_paddr = 32'h0000_0304;
    cyc();
    for (int i = 0; i < 8; i++) begin
      if (bus_err === 1'b1) err_cnt++;
      total++;
      if (data_req !== 1'b1 || bus_err !== 1'b0 || dbus_streq !== 1'b1) begin
        bad++; $display("FAIL tmo_wait[%0d]: req=%b err=%b streq=%b want 1 0 1", i, data_req, bus_err, dbus_streq);
      end
      cyc();
    end
    total++; if (bus_err !== 1'b1 || dbus_rdata !== 32'h0 || dbus_streq !== 1'b0 || data_req !== 1'b0) begin
      bad++; $display("FAIL tmo_abort: err=%b rdata=%h streq=%b req=%b want 1 0 0 0", bus_err, dbus_rdata, dbus_streq, data_req);
    end
    if (bus_err === 1'b1) err_cnt++;
    dbus_en = 1'b0;
    cyc();
    if (bus_err === 1'b1) err_cnt++;
    total++; if (err_cnt !== 1 || dbus_streq !== 1'b0) begin
      bad++; $display("FAIL tmo_single_pulse: pulses=%0d streq=%b want 1 0", err_cnt, dbus_streq);
    end
    total++; if (hs_cnt !== hs0) begin bad++; $display("FAIL tmo_no_hs: got=%0d want=0", hs_cnt - hs0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_size_map();
    test_delayed_accept();
    test_pipeline_hold();
    test_reset_midop();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
